// File: rtl/flex_timer.sv
// Programmable down-counting timer with pause, stop, restart and auto-reload.
// Define FLEX_TIMER_PRESCALE_EN to slow the decrement tick to once every PRESCALE cycles.
module flex_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("flex_timer: PRESCALE must be >= 1");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             mode_q, mode_n;
  logic             done_n, expired_n, busy_n;
  logic             tick;

`ifdef FLEX_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_n;

  assign tick = (state == RUN) && (presc_q == PW'(PRESCALE - 1));

  // Prescale counter only runs in RUN; it restarts from zero on start, stop and HOLD entry
  always_comb begin
    presc_n = '0;
    if (!stop && !start && state == RUN && !pause && !tick)
      presc_n = presc_q + PW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      presc_q <= '0;
    else
      presc_q <= presc_n;
  end
`else
  assign tick = (state == RUN);
`endif

  // Priority is stop > start > pause > tick
  always_comb begin
    state_n   = state;
    count_n   = count_out;
    reload_n  = reload_q;
    mode_n    = mode_q;
    done_n    = 1'b0;
    expired_n = expired;

    if (stop) begin
      state_n   = IDLE;
      count_n   = '0;
      expired_n = 1'b0;
    end else if (start) begin
      reload_n  = load_val;
      mode_n    = auto_reload;
      expired_n = 1'b0;
      if (load_val == '0) begin
        state_n   = DONE;
        count_n   = '0;
        done_n    = 1'b1;
        expired_n = 1'b1;
      end else begin
        state_n = RUN;
        count_n = load_val;
      end
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_n = HOLD;
          end else if (tick) begin
            // Count of 1 (or an unexpected 0) expires instead of wrapping
            if (count_out <= WIDTH'(1)) begin
              done_n    = 1'b1;
              expired_n = 1'b1;
              if (mode_q) begin
                count_n = reload_q;
              end else begin
                count_n = '0;
                state_n = DONE;
              end
            end else begin
              count_n = count_out - WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (!pause)
            state_n = RUN;
        end
        DONE: begin
          count_n   = '0;
          expired_n = 1'b1;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    busy_n = (state_n == RUN) || (state_n == HOLD);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      count_out <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      done      <= 1'b0;
      expired   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      count_out <= count_n;
      reload_q  <= reload_n;
      mode_q    <= mode_n;
      done      <= done_n;
      expired   <= expired_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_flex_timer.sv
// Directed self-checking bench for flex_timer (WIDTH=4, prescaler disabled).
`timescale 1ns/1ps
module tb_flex_timer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       start, stop, pause, auto_reload;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic       busy, done, expired;

  int n_compared   = 0;
  int n_mismatched = 0;

  flex_timer #(.WIDTH(4), .PRESCALE(4)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .load_val(load_val), .count_out(count_out),
    .busy(busy), .done(done), .expired(expired)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; pause = 1'b0; auto_reload = 1'b0; load_val = 4'd0;
  endtask

  task automatic do_stop();
    idle_inputs();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #12;
    n_compared += 4;
    if (count_out !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_count got=%0d exp=0", count_out); end
    if (busy !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    if (expired !== 1'b0)   begin n_mismatched++; $display("[TB] FAIL reset_expired got=%b exp=0", expired); end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_one_shot();
    start = 1'b1; load_val = 4'd5;
    step();
    start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) step();
      n_compared += 2;
      if (count_out !== 4'(5 - i)) begin n_mismatched++; $display("[TB] FAIL oneshot_count[%0d] got=%0d exp=%0d", i, count_out, 5 - i); end
      if (done !== (i == 5))       begin n_mismatched++; $display("[TB] FAIL oneshot_done[%0d] got=%b exp=%b", i, done, (i == 5)); end
    end
    n_compared += 2;
    if (expired !== 1'b1) begin n_mismatched++; $display("[TB] FAIL oneshot_expired got=%b exp=1", expired); end
    if (busy !== 1'b0)    begin n_mismatched++; $display("[TB] FAIL oneshot_busy got=%b exp=0", busy); end
    step();
    n_compared += 2;
    if (count_out !== 4'd0) begin n_mismatched++; $display("[TB] FAIL oneshot_hold0 got=%0d exp=0", count_out); end
    if (done !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL oneshot_done_once got=%b exp=0", done); end
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_cnt;
    logic       exp_done;
    start = 1'b1; auto_reload = 1'b1; load_val = 4'd3;
    step();
    start = 1'b0; auto_reload = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      exp_cnt  = 4'(3 - (i % 3));
      exp_done = (i > 0) && (i % 3 == 0);
      n_compared += 3;
      if (count_out !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL reload_count[%0d] got=%0d exp=%0d", i, count_out, exp_cnt); end
      if (done !== exp_done)     begin n_mismatched++; $display("[TB] FAIL reload_done[%0d] got=%b exp=%b", i, done, exp_done); end
      if (busy !== 1'b1)         begin n_mismatched++; $display("[TB] FAIL reload_busy[%0d] got=%b exp=1", i, busy); end
    end
    do_stop();
  endtask

  // Count holds at 4 for four cycles: three edges with pause high plus the resume edge
  task automatic test_pause();
    logic [3:0] exp_seq [11];
    exp_seq = '{4'd6, 4'd5, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    start = 1'b1; load_val = 4'd6;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin
        pause = (i >= 3 && i <= 5);
        step();
      end
      n_compared += 2;
      if (count_out !== exp_seq[i]) begin n_mismatched++; $display("[TB] FAIL pause_count[%0d] got=%0d exp=%0d", i, count_out, exp_seq[i]); end
      if (done !== (i == 10))       begin n_mismatched++; $display("[TB] FAIL pause_done[%0d] got=%b exp=%b", i, done, (i == 10)); end
      if (i >= 3 && i <= 6) begin
        n_compared++;
        if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pause_busy[%0d] got=%b exp=1", i, busy); end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_zero_load();
    start = 1'b1; load_val = 4'd0; auto_reload = 1'b1;
    step();
    start = 1'b0; auto_reload = 1'b0;
    n_compared += 3;
    if (done !== 1'b1)      begin n_mismatched++; $display("[TB] FAIL zero_done got=%b exp=1", done); end
    if (count_out !== 4'd0) begin n_mismatched++; $display("[TB] FAIL zero_count got=%0d exp=0", count_out); end
    if (busy !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL zero_busy got=%b exp=0", busy); end
    pause = 1'b1;
    step();
    pause = 1'b0;
    n_compared += 3;
    if (done !== 1'b0)    begin n_mismatched++; $display("[TB] FAIL zero_done_once got=%b exp=0", done); end
    if (busy !== 1'b0)    begin n_mismatched++; $display("[TB] FAIL zero_pause_busy got=%b exp=0", busy); end
    if (expired !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_expired got=%b exp=1", expired); end
  endtask

  task automatic test_stop_start();
    start = 1'b1; load_val = 4'd7;
    step();
    start = 1'b0;
    step();
    stop = 1'b1; start = 1'b1; load_val = 4'd5;
    step();
    idle_inputs();
    n_compared += 4;
    if (count_out !== 4'd0) begin n_mismatched++; $display("[TB] FAIL stopstart_count got=%0d exp=0", count_out); end
    if (busy !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL stopstart_busy got=%b exp=0", busy); end
    if (done !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL stopstart_done got=%b exp=0", done); end
    if (expired !== 1'b0)   begin n_mismatched++; $display("[TB] FAIL stopstart_expired got=%b exp=0", expired); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; load_val = 4'd5;
    step();
    start = 1'b0;
    step(); step(); step();
    n_compared++;
    if (count_out !== 4'd2) begin n_mismatched++; $display("[TB] FAIL restart_pre got=%0d exp=2", count_out); end
    start = 1'b1; load_val = 4'd9;
    step();
    start = 1'b0;
    n_compared += 2;
    if (count_out !== 4'd9) begin n_mismatched++; $display("[TB] FAIL restart_count got=%0d exp=9", count_out); end
    if (done !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL restart_done got=%b exp=0", done); end
    step();
    n_compared += 2;
    if (count_out !== 4'd8) begin n_mismatched++; $display("[TB] FAIL restart_next got=%0d exp=8", count_out); end
    if (done !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL restart_done2 got=%b exp=0", done); end
    do_stop();
  endtask

  task automatic test_max_load();
    int cycles;
    cycles = 0;
    start = 1'b1; load_val = 4'd15;
    step();
    start = 1'b0;
    while (done !== 1'b1 && cycles < 30) begin
      step();
      cycles++;
    end
    n_compared += 2;
    if (cycles !== 15)      begin n_mismatched++; $display("[TB] FAIL max_latency got=%0d exp=15", cycles); end
    if (count_out !== 4'd0) begin n_mismatched++; $display("[TB] FAIL max_count got=%0d exp=0", count_out); end
    do_stop();
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; load_val = 4'd9;
    step();
    start = 1'b0;
    step(); step();
    nRST = 1'b0;
    #1;
    n_compared += 4;
    if (count_out !== 4'd0) begin n_mismatched++; $display("[TB] FAIL midreset_count got=%0d exp=0", count_out); end
    if (busy !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)      begin n_mismatched++; $display("[TB] FAIL midreset_done got=%b exp=0", done); end
    if (expired !== 1'b0)   begin n_mismatched++; $display("[TB] FAIL midreset_expired got=%b exp=0", expired); end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_zero_load();
    test_stop_start();
    test_back_to_back();
    test_max_load();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
